// File: rtl/dcache_if.sv
// Request/response bundle for dcache: memory-stage request side plus the backing memory port.
// slave = the cache, master = the memory stage and backing memory around it.
interface dcache_if;
  logic        dcache_en;
  logic        dcache_wren;
  logic [63:0] dcache_addr;
  logic [63:0] dcache_wdata;
  logic [63:0] dcache_rdata;
  logic        dcache_done;
  logic        mem_req;
  logic        mem_we;
  logic [63:0] mem_addr;
  logic [63:0] mem_wdata;
  logic [63:0] mem_rdata;
  logic        mem_ack;

  modport slave (
    input  dcache_en, dcache_wren, dcache_addr, dcache_wdata, mem_rdata, mem_ack,
    output dcache_rdata, dcache_done, mem_req, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output dcache_en, dcache_wren, dcache_addr, dcache_wdata, mem_rdata, mem_ack,
    input  dcache_rdata, dcache_done, mem_req, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/dcache.sv
// Direct-mapped, write-through, no-write-allocate data cache with one 64-bit word per line.
// Define DCACHE_STATS_EN to add the stat_hits / stat_misses read counters.
module dcache #(
  parameter int IDX_BITS = 6
) (
  input  logic        clk,
  input  logic        rst_n,
  dcache_if.slave     bus
`ifdef DCACHE_STATS_EN
  ,
  output logic [31:0] stat_hits,
  output logic [31:0] stat_misses
`endif
);
  localparam int LINES    = 1 << IDX_BITS;
  localparam int TAG_BITS = 61 - IDX_BITS;

  typedef enum logic {IDLE, MEM} state_t;

  state_t              state_reg, state_next;
  logic [LINES-1:0]    valid_reg;
  logic [TAG_BITS-1:0] tag_mem  [LINES];
  logic [63:0]         data_mem [LINES];

  logic [63:3]         addr_reg;
  logic [63:0]         wdata_reg;
  logic [63:0]         rdata_reg;
  logic                wren_reg;
  logic                done_reg;

  logic [IDX_BITS-1:0] idx_in, idx_reg;
  logic [TAG_BITS-1:0] tag_in, tag_reg;
  logic                accept, hit, read_hit, read_miss, mem_done, fill;

  assign idx_in  = bus.dcache_addr[3+IDX_BITS-1:3];
  assign tag_in  = bus.dcache_addr[63:3+IDX_BITS];
  assign idx_reg = addr_reg[3+IDX_BITS-1:3];
  assign tag_reg = addr_reg[63:3+IDX_BITS];

  assign accept    = (state_reg == IDLE) && bus.dcache_en;
  assign hit       = valid_reg[idx_in] && (tag_mem[idx_in] == tag_in);
  assign read_hit  = accept && !bus.dcache_wren && hit;
  assign read_miss = accept && !bus.dcache_wren && !hit;
  assign mem_done  = (state_reg == MEM) && bus.mem_ack;
  assign fill      = mem_done && !wren_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_reg <= IDLE;
    else        state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (bus.dcache_en && (bus.dcache_wren || !hit)) state_next = MEM;
      MEM:     if (bus.mem_ack) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    bus.mem_req = 1'b0;
    bus.mem_we  = 1'b0;
    if (state_reg == MEM) begin
      bus.mem_req = 1'b1;
      bus.mem_we  = wren_reg;
    end
  end

  // The latched request stays on the memory port so it is stable while waiting for ack.
  assign bus.mem_addr     = {addr_reg, 3'b000};
  assign bus.mem_wdata    = wdata_reg;
  assign bus.dcache_rdata = rdata_reg;
  assign bus.dcache_done  = done_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_reg  <= '0;
      wdata_reg <= '0;
      wren_reg  <= 1'b0;
      rdata_reg <= '0;
      done_reg  <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      if (accept) begin
        addr_reg  <= bus.dcache_addr[63:3];
        wdata_reg <= bus.dcache_wdata;
        wren_reg  <= bus.dcache_wren;
      end
      if (read_hit) begin
        rdata_reg <= data_mem[idx_in];
        done_reg  <= 1'b1;
      end
      if (mem_done) begin
        done_reg <= 1'b1;
        if (!wren_reg) rdata_reg <= bus.mem_rdata;
      end
    end
  end

  // Valid bits are the only per-line state that reset touches.
  for (genvar gi = 0; gi < LINES; gi++) begin : g_valid
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                                    valid_reg[gi] <= 1'b0;
      else if (fill && (idx_reg == IDX_BITS'(gi)))   valid_reg[gi] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (accept && bus.dcache_wren && hit) begin
      data_mem[idx_in] <= bus.dcache_wdata;
    end else if (fill) begin
      tag_mem[idx_reg]  <= tag_reg;
      data_mem[idx_reg] <= bus.mem_rdata;
    end
  end

`ifdef DCACHE_STATS_EN
  logic [31:0] hits_reg, misses_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hits_reg   <= '0;
      misses_reg <= '0;
    end else begin
      if (read_hit)  hits_reg   <= hits_reg + 32'd1;
      if (read_miss) misses_reg <= misses_reg + 32'd1;
    end
  end

  assign stat_hits   = hits_reg;
  assign stat_misses = misses_reg;
`endif

endmodule

// File: tb/tb_dcache.sv
// Randomized scoreboard bench for dcache: a behavioural cache/memory model predicts each
// completion; independent monitor and memory-responder processes compare what the DUT presents.
module tb_dcache;
  localparam int IDX   = 6;
  localparam int LINES = 64;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  dcache_if bus();
`ifdef DCACHE_STATS_EN
  logic [31:0] stat_hits, stat_misses;
`endif

  dcache #(.IDX_BITS(IDX)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
`ifdef DCACHE_STATS_EN
    ,
    .stat_hits   (stat_hits),
    .stat_misses (stat_misses)
`endif
  );

  int checks = 0;
  int errors = 0;

  typedef struct {
    bit          wr;
    bit          hit;
    logic [63:0] rdata;
  } exp_t;

  typedef struct {
    bit          we;
    logic [63:0] addr;
    logic [63:0] wdata;
  } mreq_t;

  exp_t  exp_q[$];
  mreq_t mexp_q[$];

  // Reference model: line table plus a sparse backing memory.
  bit          m_vld  [LINES];
  logic [63:0] m_tag  [LINES];
  logic [63:0] m_data [LINES];
  logic [63:0] mem_m  [logic [63:0]];
  logic [63:0] m_rdata = '0;
  int unsigned m_hits = 0, m_misses = 0;

  int ack_delay   = -1;
  bit resp_en     = 1'b1;
  bit inject_ack  = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] mem_read(input logic [63:0] wa);
    if (mem_m.exists(wa)) return mem_m[wa];
    return {wa[31:0] ^ 32'h5a5a_c3c3, ~wa[63:32]};
  endfunction

  // Issue one request at posedge+1 and wait for its completion; returns inside the done cycle
  // so the next call is accepted back-to-back.
  task automatic issue(input bit wr, input logic [63:0] addr, input logic [63:0] wdata);
    int          idx, cyc;
    logic [63:0] tag, wa;
    bit          hit;
    exp_t        e;
    mreq_t       m;
    wa  = {addr[63:3], 3'b000};
    idx = int'((addr >> 3) % LINES);
    tag = addr >> (3 + IDX);
    hit = m_vld[idx] && (m_tag[idx] == tag);
    if (!wr) begin
      if (hit) begin
        m_rdata = m_data[idx];
        m_hits++;
      end else begin
        m_rdata     = mem_read(wa);
        m_vld[idx]  = 1'b1;
        m_tag[idx]  = tag;
        m_data[idx] = m_rdata;
        m_misses++;
      end
    end else begin
      mem_m[wa] = wdata;
      if (hit) m_data[idx] = wdata;
    end
    e.wr = wr; e.hit = hit; e.rdata = m_rdata;
    m.we = wr; m.addr = wa; m.wdata = wdata;

    bus.dcache_en    = 1'b1;
    bus.dcache_wren  = wr;
    bus.dcache_addr  = addr;
    bus.dcache_wdata = wdata;
    @(posedge clk);
    #1;
    bus.dcache_en    = 1'b0;
    bus.dcache_wren  = 1'($urandom_range(0, 1));
    bus.dcache_addr  = {$urandom, $urandom};
    bus.dcache_wdata = {$urandom, $urandom};
    exp_q.push_back(e);
    if (wr || !hit) mexp_q.push_back(m);
    chk("req_rise", 64'(bus.mem_req), 64'(wr || !hit));

    cyc = 0;
    while (bus.dcache_done !== 1'b1 && cyc < 30) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    if (bus.dcache_done !== 1'b1) begin
      checks++;
      errors++;
      $display("FAIL done_timeout actual=no_done required=done addr=%h", addr);
    end else if (!wr && hit) begin
      chk("hit_latency", 64'(cyc), 64'd0);
    end else begin
      chk("miss_latency_min", 64'(cyc >= 1), 64'd1);
    end
    $display("txn %s addr=%h wdata=%h hit=%0d rdata=%h cycles=%0d",
             wr ? "WR" : "RD", addr, wdata, hit, m_rdata, cyc);
  endtask

  // Monitor: pops one expectation per dcache_done pulse.
  initial begin : monitor
    bit   saw_req;
    exp_t e;
    saw_req = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        saw_req = 1'b0;
      end else begin
        if (bus.mem_req) saw_req = 1'b1;
        if (bus.dcache_done) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL spurious_done actual=done required=no_done");
          end else begin
            e = exp_q.pop_front();
            chk("rdata", bus.dcache_rdata, e.rdata);
            chk("went_to_mem", 64'(saw_req), 64'(e.wr || !e.hit));
          end
          saw_req = 1'b0;
        end
      end
    end
  end

  // Backing memory: checks each request, then acks after a random delay.
  initial begin : responder
    mreq_t m;
    int    d;
    bus.mem_ack   = 1'b0;
    bus.mem_rdata = '0;
    forever begin
      @(negedge clk);
      if (inject_ack) begin
        bus.mem_ack   = 1'b1;
        bus.mem_rdata = 64'h0BAD_0BAD_0BAD_0BAD;
        @(posedge clk);
        #1;
        bus.mem_ack = 1'b0;
        inject_ack  = 1'b0;
      end else if (rst_n && resp_en && bus.mem_req) begin
        if (mexp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_mem_req actual=req addr=%h required=none", bus.mem_addr);
          m.we = bus.mem_we; m.addr = bus.mem_addr; m.wdata = bus.mem_wdata;
        end else begin
          m = mexp_q.pop_front();
          chk("mem_we", 64'(bus.mem_we), 64'(m.we));
          chk("mem_addr", bus.mem_addr, m.addr);
          if (m.we) chk("mem_wdata", bus.mem_wdata, m.wdata);
        end
        d = (ack_delay >= 0) ? ack_delay : int'($urandom_range(0, 3));
        repeat (d) begin
          @(negedge clk);
          chk("req_hold", 64'(bus.mem_req), 64'd1);
          chk("addr_hold", bus.mem_addr, m.addr);
        end
        bus.mem_ack   = 1'b1;
        bus.mem_rdata = m.we ? {$urandom, $urandom} : mem_read(m.addr);
        @(posedge clk);
        #1;
        bus.mem_ack   = 1'b0;
        bus.mem_rdata = {$urandom, $urandom};
        @(negedge clk);
        chk("req_drop", 64'(bus.mem_req), 64'd0);
      end
    end
  end

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    bus.dcache_en    = 1'b0;
    bus.dcache_wren  = 1'b0;
    bus.dcache_addr  = '0;
    bus.dcache_wdata = '0;
    for (int i = 0; i < LINES; i++) m_vld[i] = 1'b0;
    mem_m[64'h1000] = 64'hDEAD_BEEF;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_done",  64'(bus.dcache_done), 64'd0);
    chk("rst_rdata", bus.dcache_rdata, 64'd0);
    chk("rst_req",   64'(bus.mem_req), 64'd0);
    chk("rst_we",    64'(bus.mem_we), 64'd0);
    chk("rst_addr",  bus.mem_addr, 64'd0);
    chk("rst_wdata", bus.mem_wdata, 64'd0);
`ifdef DCACHE_STATS_EN
    chk("rst_stat_hits",   64'(stat_hits), 64'd0);
    chk("rst_stat_misses", 64'(stat_misses), 64'd0);
`endif
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Directed scenarios: cold miss, offset hit, write hit, write miss, conflict.
    ack_delay = 3;
    issue(1'b0, 64'h1000, 64'h0);
    ack_delay = -1;
    issue(1'b0, 64'h1004, 64'h0);
    chk("dir_rdata_deadbeef", bus.dcache_rdata, 64'hDEAD_BEEF);
`ifdef DCACHE_STATS_EN
    chk("stat_hits_dir",   64'(stat_hits), 64'd1);
    chk("stat_misses_dir", 64'(stat_misses), 64'd1);
`endif
    issue(1'b1, 64'h1000, 64'h55);
    issue(1'b0, 64'h1000, 64'h0);
    chk("dir_rdata_55", bus.dcache_rdata, 64'h55);
    issue(1'b1, 64'h2000, 64'h1234_5678_9abc_def0);
    issue(1'b0, 64'h2000, 64'h0);
    issue(1'b0, 64'h1000, 64'h0);
    issue(1'b0, 64'h1200, 64'h0);
    issue(1'b0, 64'h1000, 64'h0);

    // Reset while a miss is outstanding; the memory never answers it.
    resp_en = 1'b0;
    @(posedge clk);
    #1;
    bus.dcache_en   = 1'b1;
    bus.dcache_wren = 1'b0;
    bus.dcache_addr = 64'h7_0000;
    @(posedge clk);
    #1;
    bus.dcache_en = 1'b0;
    chk("rst_mid_req_up", 64'(bus.mem_req), 64'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_mid_req", 64'(bus.mem_req), 64'd0);
    chk("rst_mid_done", 64'(bus.dcache_done), 64'd0);
    chk("rst_mid_addr", bus.mem_addr, 64'd0);
    chk("rst_mid_rdata", bus.dcache_rdata, 64'd0);
    for (int i = 0; i < LINES; i++) m_vld[i] = 1'b0;
    m_rdata  = '0;
    m_hits   = 0;
    m_misses = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    inject_ack = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("late_ack_no_done", 64'(bus.dcache_done), 64'd0);
    chk("late_ack_no_req", 64'(bus.mem_req), 64'd0);
    @(posedge clk);
    #1;
    chk("late_ack_no_done2", 64'(bus.dcache_done), 64'd0);
    resp_en = 1'b1;
    issue(1'b0, 64'h1000, 64'h0);

    // Random traffic over a small address pool so hits, misses and conflicts all occur.
    for (int i = 0; i < 400; i++) begin
      logic [63:0] a;
      bit          wr;
      a = (64'($urandom_range(0, 3)) << 9) | (64'($urandom_range(0, 7)) << 3) |
          64'($urandom_range(0, 7));
      if ($urandom_range(0, 9) == 0) a[63:32] = $urandom;
      wr = ($urandom_range(0, 99) < 30);
      issue(wr, a, {$urandom, $urandom});
      if ($urandom_range(0, 3) == 0) begin
        repeat ($urandom_range(1, 3)) begin
          @(posedge clk);
          #1;
        end
      end
    end

    repeat (4) @(posedge clk);
    #1;
    chk("exp_q_empty", 64'(exp_q.size()), 64'd0);
    chk("mexp_q_empty", 64'(mexp_q.size()), 64'd0);
`ifdef DCACHE_STATS_EN
    chk("stat_hits_final",   64'(stat_hits), 64'(m_hits));
    chk("stat_misses_final", 64'(stat_misses), 64'(m_misses));
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
